// File: rtl/stream_acc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : stream_acc_pkg                                                  |
// | Purpose  : Shared types and width/saturation helpers for the multi-lane    |
// |            streaming accumulator.                                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package stream_acc_pkg;

    typedef enum logic {
        ACC_IDLE  = 1'b0,
        ACC_ACCUM = 1'b1
    } acc_state_t;

    // Room for the lane reduction, the vector-length growth and the sign bit.
    function automatic int acc_bits(input int bits, input int lanes, input int max_len);
        return bits + $clog2(lanes) + $clog2(max_len) + 1;
    endfunction

    function automatic longint sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_adder_tree.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lane_adder_tree                                                 |
// | Purpose  : Combinational sign-extending binary reduction of packed lanes.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module lane_adder_tree #(
    parameter int BITS     = 8,
    parameter int LANES    = 4,
    parameter int OUT_BITS = 16
) (
    input  logic [LANES*BITS-1:0]      a,
    output logic signed [OUT_BITS-1:0] sum
);

    // Leaves padded to a power of two; node n has children 2n+1 and 2n+2.
    localparam int LEAVES = (LANES <= 1) ? 1 : (1 << $clog2(LANES));

    logic signed [OUT_BITS-1:0] w_node [0:2*LEAVES-2];

    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
        if (i < LANES) begin : g_lane
            assign w_node[LEAVES-1+i] = OUT_BITS'(signed'(a[i*BITS +: BITS]));
        end else begin : g_pad
            assign w_node[LEAVES-1+i] = '0;
        end
    end

    for (genvar n = 0; n < LEAVES - 1; n++) begin : g_node
        assign w_node[n] = w_node[2*n+1] + w_node[2*n+2];
    end

    assign sum = w_node[0];

endmodule
`default_nettype wire

// File: rtl/stream_accumulate_lanes.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stream_accumulate_lanes                                         |
// | Purpose  : Multi-lane streaming accumulator, one widened sum per vector    |
// |            of runtime length, valid/ready in and out. Optional saturation  |
// |            with sticky overflow flag when STREAM_ACC_SAT_EN is defined.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module stream_accumulate_lanes
    import stream_acc_pkg::*;
#(
    parameter int BITS     = 8,
    parameter int LANES    = 4,
    parameter int MAX_LEN  = 10,
    parameter int ACC_BITS = acc_bits(BITS, LANES, MAX_LEN),
    parameter int LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       clear,
    input  logic [LEN_W-1:0]           len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*BITS-1:0]      a,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [ACC_BITS-1:0] c,
    output logic                       out_ovf
);

    acc_state_t                 r_state;
    logic [LEN_W-1:0]           r_len_q;
    logic [LEN_W-1:0]           r_count;
    logic signed [ACC_BITS-1:0] r_acc;
    logic signed [ACC_BITS-1:0] r_c;
    logic                       r_out_valid;

    logic signed [ACC_BITS-1:0] w_tree_sum;
    logic signed [ACC_BITS-1:0] w_add_result;
    logic [LEN_W-1:0]           w_len_clamped;
    logic [LEN_W-1:0]           w_len_eff;
    logic                       w_first;
    logic                       w_beat;
    logic                       w_final;

    lane_adder_tree #(
        .BITS     (BITS),
        .LANES    (LANES),
        .OUT_BITS (ACC_BITS)
    ) u_tree (
        .a   (a),
        .sum (w_tree_sum)
    );

    always_comb begin
        w_len_clamped = len;
        if (len == '0) begin
            w_len_clamped = LEN_W'(1);
        end else if (len > LEN_W'(MAX_LEN)) begin
            w_len_clamped = LEN_W'(MAX_LEN);
        end
    end

    // Accumulator and count are zero whenever the FSM is idle, so the first
    // beat needs no special operand selection; only the length is live-sampled.
    assign w_first   = (r_state == ACC_IDLE);
    assign w_len_eff = w_first ? w_len_clamped : r_len_q;
    assign in_ready  = !(r_out_valid && !out_ready);
    assign w_beat    = in_valid && in_ready;
    assign w_final   = ((r_count + LEN_W'(1)) == w_len_eff);

`ifdef STREAM_ACC_SAT_EN
    localparam logic signed [ACC_BITS-1:0] SAT_MAX = ACC_BITS'(sat_max(ACC_BITS));
    localparam logic signed [ACC_BITS-1:0] SAT_MIN = ACC_BITS'(sat_min(ACC_BITS));

    logic signed [ACC_BITS:0] w_exact;
    logic                     w_ovf_now;
    logic                     w_sticky_next;
    logic                     r_sticky;
    logic                     r_out_ovf;

    assign w_exact       = (ACC_BITS+1)'(r_acc) + (ACC_BITS+1)'(w_tree_sum);
    assign w_ovf_now     = w_exact[ACC_BITS] ^ w_exact[ACC_BITS-1];
    assign w_sticky_next = (w_first ? 1'b0 : r_sticky) | w_ovf_now;

    always_comb begin
        w_add_result = w_exact[ACC_BITS-1:0];
        if (w_ovf_now) begin
            w_add_result = w_exact[ACC_BITS] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sticky  <= 1'b0;
            r_out_ovf <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_ovf <= 1'b0;
            end
            if (clear) begin
                r_sticky <= 1'b0;
            end else if (w_beat) begin
                if (w_final) begin
                    r_out_ovf <= w_sticky_next;
                    r_sticky  <= 1'b0;
                end else begin
                    r_sticky  <= w_sticky_next;
                end
            end
        end
    end

    assign out_ovf = r_out_ovf;
`else
    assign w_add_result = r_acc + w_tree_sum;
    assign out_ovf      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ACC_IDLE;
            r_len_q     <= '0;
            r_count     <= '0;
            r_acc       <= '0;
            r_c         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // Drain first so a final beat in the same cycle reloads the register.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
                r_c         <= '0;
            end
            if (clear) begin
                r_state <= ACC_IDLE;
                r_count <= '0;
                r_acc   <= '0;
            end else if (w_beat) begin
                if (w_final) begin
                    r_c         <= w_add_result;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_count     <= '0;
                    r_state     <= ACC_IDLE;
                end else begin
                    r_acc       <= w_add_result;
                    r_count     <= r_count + LEN_W'(1);
                    r_len_q     <= w_len_eff;
                    r_state     <= ACC_ACCUM;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign c         = r_c;

endmodule
`default_nettype wire

// File: tb/tb_stream_accumulate_lanes.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_stream_accumulate_lanes                                      |
// | Purpose  : Self-checking bench with random beats against a sum-of-lanes    |
// |            reference; saturation scenario under STREAM_ACC_SAT_EN.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_stream_accumulate_lanes;

    localparam int BITS     = 8;
    localparam int LANES    = 4;
    localparam int MAX_LEN  = 10;
    localparam int ACC_BITS = BITS + $clog2(LANES) + $clog2(MAX_LEN) + 1;
    localparam int LEN_W    = $clog2(MAX_LEN + 1);

    logic                       clk = 1'b0;
    logic                       rstn;
    logic                       clear;
    logic [LEN_W-1:0]           len;
    logic                       in_valid;
    logic                       in_ready;
    logic [LANES*BITS-1:0]      a;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [ACC_BITS-1:0] c;
    logic                       out_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_accumulate_lanes #(
        .BITS    (BITS),
        .LANES   (LANES),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (clear),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .out_ovf   (out_ovf)
    );

`ifdef STREAM_ACC_SAT_EN
    localparam int SAT_BITS = 10;
    logic                       s_in_ready;
    logic                       s_out_valid;
    logic signed [SAT_BITS-1:0] s_c;
    logic                       s_ovf;

    stream_accumulate_lanes #(
        .BITS     (BITS),
        .LANES    (LANES),
        .MAX_LEN  (MAX_LEN),
        .ACC_BITS (SAT_BITS)
    ) dut_sat (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (clear),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .a         (a),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .c         (s_c),
        .out_ovf   (s_ovf)
    );
`endif

    // Reference: a beat contributes the plain signed sum of its lanes.
    function automatic longint beat_sum(input logic [LANES*BITS-1:0] d);
        longint s = 0;
        for (int i = 0; i < LANES; i++) begin
            s += longint'(signed'(d[i*BITS +: BITS]));
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [LANES*BITS-1:0] d, input int l);
        int n = 0;
        a = d;
        len = LEN_W'(l);
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        a = '0;
    endtask

    task automatic send_vector(input int l, input int gap, output longint s);
        int n;
        logic [LANES*BITS-1:0] d;
        n = (l == 0) ? 1 : ((l > MAX_LEN) ? MAX_LEN : l);
        s = 0;
        for (int b = 0; b < n; b++) begin
            d = $urandom;
            s += beat_sum(d);
            send_beat(d, (b == 0) ? l : int'($urandom_range(0, 15)));
            if (b < n - 1) repeat (gap) tick();
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; len = '0;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++;
        if (c !== '0) begin errors++; $display("FAIL reset_c: got %0d required 0", c); end
        checks++;
        if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %b required 0", out_ovf); end
        @(negedge clk);
        rstn = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            send_beat(32'h01010101, (b == 0) ? 3 : 7);
            checks++;
            if (out_valid !== (b == 2)) begin
                errors++; $display("FAIL basic_valid_beat%0d: got %b required %b", b, out_valid, (b == 2));
            end
        end
        checks++;
        if (c !== ACC_BITS'(12)) begin errors++; $display("FAIL basic_sum: got %0d required 12", c); end
        tick();
        checks++;
        if (out_valid !== 1'b0 || c !== '0) begin
            errors++; $display("FAIL basic_drain: out_valid=%b c=%0d required 0/0", out_valid, c);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [ACC_BITS-1:0] exp_c;
        exp_c = ACC_BITS'(beat_sum(32'h017F8080));
        out_ready = 1'b1;
        a = 32'h017F8080;
        len = LEN_W'(1);
        in_valid = 1'b1;
        for (int v = 0; v < 5; v++) begin
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready%0d: got %b required 1", v, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || c !== exp_c) begin
                errors++; $display("FAIL b2b_result%0d: out_valid=%b c=%0d required 1/%0d", v, out_valid, c, exp_c);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        longint s1, s2;
        logic [LANES*BITS-1:0] d;
        out_ready = 1'b0;
        send_vector(2, 0, s1);
        checks++;
        if (out_valid !== 1'b1 || c !== ACC_BITS'(s1)) begin
            errors++; $display("FAIL bp_first: out_valid=%b c=%0d required 1/%0d", out_valid, c, ACC_BITS'(s1));
        end
        d = $urandom;
        s2 = beat_sum(d);
        a = d; len = LEN_W'(2); in_valid = 1'b1;
        repeat (3) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || c !== ACC_BITS'(s1)) begin
                errors++; $display("FAIL bp_hold: in_ready=%b out_valid=%b c=%0d required 0/1/%0d",
                                   in_ready, out_valid, c, ACC_BITS'(s1));
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: in_ready=%b required 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: out_valid=%b required 0", out_valid); end
        d = $urandom;
        s2 += beat_sum(d);
        send_beat(d, 9);
        checks++;
        if (out_valid !== 1'b1 || c !== ACC_BITS'(s2)) begin
            errors++; $display("FAIL bp_second: out_valid=%b c=%0d required 1/%0d", out_valid, c, ACC_BITS'(s2));
        end
        tick();
    endtask

    task automatic test_stall_clear();
        longint s;
        out_ready = 1'b1;
        send_vector(4, 2, s);
        checks++;
        if (out_valid !== 1'b1 || c !== ACC_BITS'(s)) begin
            errors++; $display("FAIL stall_sum: out_valid=%b c=%0d required 1/%0d", out_valid, c, ACC_BITS'(s));
        end
        tick();
        send_beat($urandom, 4);
        send_beat($urandom, 4);
        clear = 1'b1; in_valid = 1'b1; a = $urandom;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        repeat (3) begin
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_no_output: out_valid=%b required 0", out_valid); end
            tick();
        end
        send_vector(2, 0, s);
        checks++;
        if (out_valid !== 1'b1 || c !== ACC_BITS'(s)) begin
            errors++; $display("FAIL clear_restart: out_valid=%b c=%0d required 1/%0d", out_valid, c, ACC_BITS'(s));
        end
        tick();
    endtask

    task automatic test_len_bounds();
        longint s;
        logic [LANES*BITS-1:0] d;
        out_ready = 1'b1;
        send_vector(0, 0, s);
        checks++;
        if (out_valid !== 1'b1 || c !== ACC_BITS'(s)) begin
            errors++; $display("FAIL len0: out_valid=%b c=%0d required 1/%0d", out_valid, c, ACC_BITS'(s));
        end
        tick();
        s = 0;
        for (int b = 0; b < MAX_LEN; b++) begin
            d = $urandom;
            s += beat_sum(d);
            send_beat(d, (b == 0) ? 15 : int'($urandom_range(0, 15)));
            if (b < MAX_LEN - 1) begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL len15_early_beat%0d: out_valid=%b required 0", b, out_valid); end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || c !== ACC_BITS'(s)) begin
            errors++; $display("FAIL len15: out_valid=%b c=%0d required 1/%0d", out_valid, c, ACC_BITS'(s));
        end
        tick();
    endtask

    task automatic test_random();
        longint s;
        int l;
        out_ready = 1'b1;
        for (int v = 0; v < 25; v++) begin
            l = $urandom_range(0, 15);
            send_vector(l, $urandom_range(0, 2), s);
            checks++;
            if (out_valid !== 1'b1 || c !== ACC_BITS'(s) || out_ovf !== 1'b0) begin
                errors++; $display("FAIL random_v%0d_len%0d: out_valid=%b c=%0d ovf=%b required 1/%0d/0",
                                   v, l, out_valid, c, out_ovf, ACC_BITS'(s));
            end
            tick();
        end
    endtask

`ifdef STREAM_ACC_SAT_EN
    task automatic test_saturation();
        logic [LANES*BITS-1:0] pat [3];
        int lens [3];
        longint acc, t, lim_hi, lim_lo;
        bit ovf;
        pat[0] = 32'h7F7F7F7F; lens[0] = 3;
        pat[1] = 32'h01010101; lens[1] = 1;
        pat[2] = 32'h80808080; lens[2] = 2;
        lim_hi = (64'sd1 <<< (SAT_BITS - 1)) - 1;
        lim_lo = -(64'sd1 <<< (SAT_BITS - 1));
        out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            acc = 0; ovf = 1'b0;
            for (int b = 0; b < lens[v]; b++) begin
                t = acc + beat_sum(pat[v]);
                if (t > lim_hi) begin t = lim_hi; ovf = 1'b1; end
                else if (t < lim_lo) begin t = lim_lo; ovf = 1'b1; end
                acc = t;
                send_beat(pat[v], lens[v]);
            end
            checks++;
            if (s_out_valid !== 1'b1 || s_c !== SAT_BITS'(acc) || s_ovf !== ovf) begin
                errors++; $display("FAIL sat_v%0d: out_valid=%b c=%0d ovf=%b required 1/%0d/%b",
                                   v, s_out_valid, s_c, s_ovf, SAT_BITS'(acc), ovf);
            end
            tick();
        end
    endtask
`endif

    task automatic test_async_reset();
        longint s;
        out_ready = 1'b0;
        send_vector(1, 0, s);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pending: out_valid=%b required 1", out_valid); end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || c !== '0 || out_ovf !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL areset_outputs: out_valid=%b c=%0d ovf=%b in_ready=%b required 0/0/0/1",
                               out_valid, c, out_ovf, in_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
        out_ready = 1'b1;
        send_beat($urandom, 4);
        send_beat($urandom, 4);
        #2 rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        send_vector(1, 0, s);
        checks++;
        if (out_valid !== 1'b1 || c !== ACC_BITS'(s)) begin
            errors++; $display("FAIL areset_restart: out_valid=%b c=%0d required 1/%0d", out_valid, c, ACC_BITS'(s));
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_stall_clear();
        test_len_bounds();
        test_random();
`ifdef STREAM_ACC_SAT_EN
        test_saturation();
`endif
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
